bcd_display_ctrl: RTL and testbench
===================================

# bcd_display_ctrl

Sequencer and display scheduler for the shared combinational binary-to-BCD converter in the camera/LCD status path. It accepts 8-bit values over a valid/ready handshake and presents each value to the external converter. After a settle cycle it captures the three BCD digits atomically. It then time-multiplexes those digits onto a common 7-segment display, with leading-zero blanking and a programmable refresh rate.

## Interface
Parameters:
- REFRESH_DIV, 50000: clock cycles each digit is displayed; legal range 2..2^20.
- BLANK_LZ, 1: 1 = blank leading zeros, 0 = always show three digits.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- val_i  in  8  binary value to display.
- val_valid  in  1  val_i is valid.
- val_ready  out  1  block can accept a value; high only in IDLE.
- conv_a  out  8  registered operand driven to the converter input.
- conv_z0  in  4  converter ones digit.
- conv_z1  in  4  converter tens digit.
- conv_z2  in  4  converter hundreds digit.
- seg_o  out  7  segments gfedcba; active-high; bit0 = a.
- dig_o  out  3  one-hot digit enable, active-high; bit0 = ones, bit2 = hundreds.
- busy  out  1  conversion in progress (state != IDLE).
- err  out  1  sticky flag: a captured digit was > 9.

## Operation
- Conversion FSM has three states: IDLE, SETTLE, CAPTURE.
  - IDLE: val_ready = 1. If val_valid is high, the handshake completes on that edge: conv_a <= val_i, and the state moves to SETTLE.
  - SETTLE: conv_a is held stable, and the converter output is allowed to settle. The state always moves to CAPTURE on the next edge.
  - CAPTURE: dig0/dig1/dig2 <= conv_z0/z1/z2, all three on the same edge. err is set if any captured digit is > 9. The state then moves to IDLE.
- conv_a holds its last value outside a conversion.
- If val_valid is high while the FSM is not in IDLE, nothing is accepted. The source must hold val_i until it sees val_ready.
- Scan:
  - A 20-bit counter counts 0..REFRESH_DIV-1. On wrap, digit index idx advances 0 -> 1 -> 2 -> 0.
  - Conversions never stall or reset the scan.
  - dig_o = one-hot(idx). seg_o = decode(digit[idx]).
- Decode: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F. Any value > 9 decodes to 40 (dash).
- Blanking (BLANK_LZ = 1):
  - Hundreds digit is blank when dig2 == 0.
  - Tens digit is blank when dig2 == 0 and dig1 == 0.
  - Ones digit is never blank.
  - When the selected digit is blank, dig_o = 000 and seg_o = 00. idx keeps advancing, so duty-cycle timing is unchanged.
- seg_o and dig_o are registered: they reflect idx and the digit registers from the previous cycle.
- err is cleared only by reset.

## Timing
- Reset values:
  - State IDLE, so val_ready = 1 and busy = 0.
  - conv_a = 00; dig0..dig2 = 0; idx = 0; counter = 0.
  - dig_o = 001; seg_o = 3F; err = 0.
- Latency for a value accepted on edge k:
  - SETTLE during cycle k..k+1; CAPTURE during k+1..k+2.
  - Digits update on edge k+2. seg_o/dig_o reflect the new digits from edge k+3.
  - val_ready is back high after edge k+2.
- Throughput: one value per 3 cycles with val_valid held high.
- Reset asserted mid-conversion: the FSM returns to IDLE immediately and the in-flight value is dropped. All outputs take their reset values.
- Counter wrap and capture on the same edge: idx advances and the digits update together. The next cycle shows the new digit at the new idx.

## Test plan
- Reset and idle: deassert rst_n, leave val_valid low -> val_ready = 1, busy = 0, dig_o = 001, seg_o = 3F, err = 0, conv_a = 00.
- Full-scale load: val_i = 255 pulsed with valid, converter model attached -> conv_a = FF next cycle; val_ready low for exactly 2 cycles; digits 2/5/5. With REFRESH_DIV = 4, seg_o sequence is 6D(001), 6D(010), 5B(100), each for 4 cycles.
- Blanking: val_i = 7, BLANK_LZ = 1 -> ones shows 07 on dig_o = 001. During idx 1 and idx 2, dig_o = 000 and seg_o = 00.
- Same value with BLANK_LZ = 0 -> 3F is shown on 010 and 100.
- Back-pressure: hold val_valid with val_i = 100 immediately after an accept of 42 -> the second accept occurs exactly 3 cycles after the first. Final digits are 1/0/0; 42 is shown in between.
- Reset mid-conversion: accept 200, assert rst_n low during SETTLE -> digits remain 0, val_ready = 1 after release, and 200 is never displayed.
- Error injection: force conv_z1 = A during CAPTURE -> err = 1 and stays 1 across later good loads. The tens position shows 40.

Source files
------------

// File: rtl/bcd_display_ctrl.sv
// Sequencer for the shared binary-to-BCD converter plus a multiplexed
// 3-digit 7-segment scanner with optional leading-zero blanking.
module bcd_display_ctrl #(
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] val_i,
  input  logic       val_valid,
  output logic       val_ready,
  output logic [7:0] conv_a,
  input  logic [3:0] conv_z0,
  input  logic [3:0] conv_z1,
  input  logic [3:0] conv_z2,
  output logic [6:0] seg_o,
  output logic [2:0] dig_o,
  output logic       busy,
  output logic       err
);

  localparam logic [19:0] CNT_MAX = 20'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} state_t;

  state_t          state_q, state_d;
  logic [7:0]      conv_a_q, conv_a_d;
  logic [2:0][3:0] dig_q, dig_d;
  logic            err_q, err_d;
  logic [19:0]     cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [6:0]      seg_q, seg_d;
  logic [2:0]      en_q, en_d;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  // Conversion FSM: operand is held in conv_a_q across SETTLE so the
  // external converter sees a stable input before the digits are sampled.
  always_comb begin
    state_d  = state_q;
    conv_a_d = conv_a_q;
    dig_d    = dig_q;
    err_d    = err_q;
    case (state_q)
      IDLE: if (val_valid) begin
        conv_a_d = val_i;
        state_d  = SETTLE;
      end
      SETTLE: state_d = CAPTURE;
      CAPTURE: begin
        dig_d   = {conv_z2, conv_z1, conv_z0};
        err_d   = err_q | (conv_z0 > 4'd9) | (conv_z1 > 4'd9) | (conv_z2 > 4'd9);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scan runs free of the FSM; blanked digits still consume their slot.
  logic       wrap, blank, lz2, lz1;
  logic [3:0] sel;
  logic [2:0] en;

  always_comb begin
    wrap  = (cnt_q == CNT_MAX);
    cnt_d = wrap ? 20'd0 : cnt_q + 20'd1;
    idx_d = idx_q;
    if (wrap) idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    lz2 = (dig_q[2] == 4'd0);
    lz1 = lz2 && (dig_q[1] == 4'd0);
    case (idx_q)
      2'd1: begin sel = dig_q[1]; en = 3'b010; blank = BLANK_LZ && lz1; end
      2'd2: begin sel = dig_q[2]; en = 3'b100; blank = BLANK_LZ && lz2; end
      default: begin sel = dig_q[0]; en = 3'b001; blank = 1'b0; end
    endcase
    seg_d = blank ? 7'h00 : decode(sel);
    en_d  = blank ? 3'b000 : en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      conv_a_q <= 8'h00;
      dig_q    <= '0;
      err_q    <= 1'b0;
      cnt_q    <= 20'd0;
      idx_q    <= 2'd0;
      seg_q    <= 7'h3F;
      en_q     <= 3'b001;
    end else begin
      state_q  <= state_d;
      conv_a_q <= conv_a_d;
      dig_q    <= dig_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      en_q     <= en_d;
    end
  end

  assign val_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign conv_a    = conv_a_q;
  assign seg_o     = seg_q;
  assign dig_o     = en_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Directed bench for bcd_display_ctrl: one blanking and one non-blanking
// instance share stimulus; each has its own behavioural converter.
module tb_bcd_display_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, val_valid, inj;
  logic [7:0] val_i;

  logic [7:0] ca, ca_nb;
  logic [3:0] z0, z1, z2, y0, y1, y2;
  logic       rdy, rdy_nb, bsy, bsy_nb, er, er_nb;
  logic [6:0] seg, seg_nb;
  logic [2:0] dig, dig_nb;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign z0 = 4'(ca % 8'd10);
  assign z1 = inj ? 4'hA : 4'((ca / 8'd10) % 8'd10);
  assign z2 = 4'(ca / 8'd100);
  assign y0 = 4'(ca_nb % 8'd10);
  assign y1 = inj ? 4'hA : 4'((ca_nb / 8'd10) % 8'd10);
  assign y2 = 4'(ca_nb / 8'd100);

  bcd_display_ctrl #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .val_i(val_i), .val_valid(val_valid),
    .val_ready(rdy), .conv_a(ca), .conv_z0(z0), .conv_z1(z1), .conv_z2(z2),
    .seg_o(seg), .dig_o(dig), .busy(bsy), .err(er));

  bcd_display_ctrl #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .val_i(val_i), .val_valid(val_valid),
    .val_ready(rdy_nb), .conv_a(ca_nb), .conv_z0(y0), .conv_z1(y1), .conv_z2(y2),
    .seg_o(seg_nb), .dig_o(dig_nb), .busy(bsy_nb), .err(er_nb));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    val_i = v;
    val_valid = 1'b1;
    tick();
    val_valid = 1'b0;
    tick();
    tick();
  endtask

  // Returns just after the edge on which the ones slot begins.
  task automatic wait_slot0();
    logic [2:0] prev;
    bit found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      prev = dig;
      tick();
      if (dig == 3'b001 && prev != 3'b001) found = 1;
    end
    if (!found) chk("slot0_timeout", 32'd0, 32'd1);
  endtask

  task automatic scan_chk(input string tag,
                          input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                          input logic [2:0] d0, input logic [2:0] d1, input logic [2:0] d2,
                          input logic [6:0] t0, input logic [6:0] t1, input logic [6:0] t2);
    logic [6:0] es[3];
    logic [2:0] ed[3];
    logic [6:0] et[3];
    logic [2:0] oh[3];
    es = '{s0, s1, s2};
    ed = '{d0, d1, d2};
    et = '{t0, t1, t2};
    oh = '{3'b001, 3'b010, 3'b100};
    wait_slot0();
    for (int i = 0; i < 12; i++) begin
      chk({tag, "_seg"},    32'(seg),    32'(es[i/4]));
      chk({tag, "_dig"},    32'(dig),    32'(ed[i/4]));
      chk({tag, "_nb_seg"}, 32'(seg_nb), 32'(et[i/4]));
      chk({tag, "_nb_dig"}, 32'(dig_nb), 32'(oh[i/4]));
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; val_valid = 1'b0; val_i = 8'h00; inj = 1'b0;
    repeat (3) tick();
    chk("rst_ready", 32'(rdy), 32'd1);
    chk("rst_busy",  32'(bsy), 32'd0);
    chk("rst_dig",   32'(dig), 32'h1);
    chk("rst_seg",   32'(seg), 32'h3F);
    chk("rst_err",   32'(er),  32'd0);
    chk("rst_conva", 32'(ca),  32'h00);
    rst_n = 1'b1;
    tick();
    chk("idle_ready", 32'(rdy), 32'd1);

    // Full-scale value 255
    val_i = 8'd255; val_valid = 1'b1;
    tick();
    chk("fs_conva",  32'(ca),  32'hFF);
    chk("fs_ready0", 32'(rdy), 32'd0);
    chk("fs_busy",   32'(bsy), 32'd1);
    val_valid = 1'b0;
    tick();
    chk("fs_ready1", 32'(rdy), 32'd0);
    tick();
    chk("fs_ready2", 32'(rdy), 32'd1);
    chk("fs_idle",   32'(bsy), 32'd0);
    scan_chk("fs", 7'h6D, 7'h6D, 7'h5B, 3'b001, 3'b010, 3'b100, 7'h6D, 7'h6D, 7'h5B);

    // Leading-zero blanking with value 7
    load(8'd7);
    scan_chk("lz7", 7'h07, 7'h00, 7'h00, 3'b001, 3'b000, 3'b000, 7'h07, 7'h3F, 7'h3F);

    // Back-pressure: 42 accepted, 100 held valid right behind it
    wait_slot0();
    val_i = 8'd42; val_valid = 1'b1;
    tick();
    chk("bp_conva42", 32'(ca),  32'h2A);
    chk("bp_ready_a", 32'(rdy), 32'd0);
    val_i = 8'd100;
    tick();
    chk("bp_ready_b", 32'(rdy), 32'd0);
    chk("bp_hold42",  32'(ca),  32'h2A);
    tick();
    chk("bp_ready_c", 32'(rdy), 32'd1);
    chk("bp_notyet",  32'(ca),  32'h2A);
    tick();
    chk("bp_conva100", 32'(ca),  32'h64);
    chk("bp_seg42a",   32'(seg), 32'h66);
    chk("bp_dig42a",   32'(dig), 32'h2);
    val_valid = 1'b0;
    tick();
    chk("bp_seg42b", 32'(seg), 32'h66);
    tick();
    tick();
    chk("bp_seg100", 32'(seg), 32'h3F);
    chk("bp_dig100", 32'(dig), 32'h2);
    scan_chk("bp100", 7'h3F, 7'h3F, 7'h06, 3'b001, 3'b010, 3'b100, 7'h3F, 7'h3F, 7'h06);

    // Reset during SETTLE drops the in-flight 200
    val_i = 8'd200; val_valid = 1'b1;
    tick();
    val_valid = 1'b0;
    chk("mr_busy_pre", 32'(bsy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_busy",  32'(bsy), 32'd0);
    chk("mr_ready", 32'(rdy), 32'd1);
    chk("mr_conva", 32'(ca),  32'h00);
    chk("mr_seg",   32'(seg), 32'h3F);
    chk("mr_dig",   32'(dig), 32'h1);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("mr_ready_post", 32'(rdy), 32'd1);
    chk("mr_busy_post",  32'(bsy), 32'd0);
    scan_chk("mr", 7'h3F, 7'h00, 7'h00, 3'b001, 3'b000, 3'b000, 7'h3F, 7'h3F, 7'h3F);

    // Illegal tens digit injected at capture
    chk("err_clear", 32'(er), 32'd0);
    inj = 1'b1;
    load(8'd5);
    inj = 1'b0;
    chk("err_set",    32'(er),    32'd1);
    chk("err_set_nb", 32'(er_nb), 32'd1);
    scan_chk("err", 7'h6D, 7'h40, 7'h00, 3'b001, 3'b010, 3'b000, 7'h6D, 7'h40, 7'h3F);
    load(8'd7);
    chk("err_sticky",    32'(er),    32'd1);
    chk("err_sticky_nb", 32'(er_nb), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
